prio_scan_encoder: RTL and testbench
====================================

PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001 Parameter WIDTH, default 16: request vector width; SHALL be ≥ 2, power of two not required.
REQ-002 Parameter MODE, default 0: 0 = single (emit only the highest-priority set bit), 1 = scan (emit every set bit, one per beat).
REQ-003 Parameter MSB_FIRST, default 0: 0 = lowest index has priority, 1 = highest index has priority.
REQ-004 Derived constants: IDX_W = clog2(WIDTH), CNT_W = clog2(WIDTH+1); not overridable.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 en  in  1  acceptance enable; low blocks new vectors only.
REQ-009 in_vec  in  WIDTH  request vector.
REQ-010 in_valid  in  1  in_vec valid.
REQ-011 in_ready  out  1  block can accept in_vec.
REQ-012 out_idx  out  IDX_W  encoded bit index.
REQ-013 out_last  out  1  final beat for the current vector.
REQ-014 out_zero  out  1  accepted vector was all zeros.
REQ-015 out_count  out  CNT_W  popcount of the accepted vector, constant for all beats of that vector.
REQ-016 out_valid  out  1  output beat valid.
REQ-017 out_ready  in  1  downstream accepts the beat.

Function
REQ-018 States: IDLE (no pending vector), EMIT (pending register holds unsent bits).
REQ-019 in_ready SHALL be en AND (state = IDLE OR (out_valid AND out_ready AND out_last)).
REQ-020 On in_valid AND in_ready, the block SHALL load pend ← in_vec and out_count ← popcount(in_vec), then enter EMIT; out_valid SHALL be 1 from the next cycle (latency 1).
REQ-021 out_idx SHALL be the index of the priority set bit of pend, selected per MSB_FIRST.
REQ-022 out_last SHALL be 1 in MODE 0; in MODE 1 it SHALL be 1 iff pend has at most one bit set.
REQ-023 If pend = 0 in EMIT, exactly one beat SHALL be emitted with out_zero = 1, out_idx = 0, out_last = 1, and out_count = 0.
REQ-024 On an output handshake with out_last = 0, the emitted bit SHALL be cleared in pend and the state SHALL remain EMIT.
REQ-025 On an output handshake with out_last = 1 and no simultaneous input acceptance, the next state SHALL be IDLE and out_valid SHALL be 0.
REQ-026 On a simultaneous last-beat handshake and input acceptance, the new vector SHALL load with no bubble cycle.
REQ-027 While out_valid = 1 and out_ready = 0, all out_* signals SHALL hold stable.
REQ-028 en = 0 SHALL NOT stall emission of a vector already accepted.
REQ-029 in_vec SHALL be sampled only on acceptance; changes afterwards SHALL have no effect.

Reset
REQ-030 While rst_n = 0, the block SHALL hold state = IDLE, pend = 0, out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0, and out_count = 0, asynchronously.
REQ-031 Reset during EMIT SHALL discard the pending vector, and no partial beat SHALL appear after release.
REQ-032 On the first edge after release, in_ready SHALL equal en.

Structure
REQ-033 Package prio_enc_pkg SHALL hold the state enum (IDLE, EMIT) and the MODE constants MODE_SINGLE = 0 and MODE_SCAN = 1.
REQ-034 Sub-module prio_find (combinational, parameters WIDTH and MSB_FIRST) SHALL return the index of the priority set bit, a found flag, and a more-than-one-bit flag.
REQ-035 The popcount SHALL be a local function in the package.

Verification (WIDTH = 16)
REQ-036 MODE 0, in_vec 16'h0400 → one beat: idx 10, last 1, count 1, zero 0, one cycle after acceptance.
REQ-037 MODE 1, MSB_FIRST 0, in_vec 16'h8012 → beats idx 1, 4, 15, with last only on 15 and count 3 on every beat; the same case with MSB_FIRST 1 → beats 15, 4, 1.
REQ-038 in_vec 16'h0000 → one beat: zero 1, idx 0, last 1, count 0; state returns to IDLE.
REQ-039 MODE 1, in_vec 16'h00F0 with out_ready low for 3 cycles after the second beat → idx 5 held stable, then beats 6 and 7, with no beat lost or duplicated.
REQ-040 Back-to-back: 16'h0003 then 16'h0100 offered continuously → in_ready high on beat idx 1, next beat idx 8 on the following cycle with no bubble; en low blocks the second vector while the first still drains.
REQ-041 rst_n pulsed low during the scan of 16'hFFFF → out_valid drops immediately; after release in_ready = 1 and no stale beat appears.

Source files
------------

// File: rtl/prio_scan_encoder_pkg.sv
// prio_enc_pkg: shared types and helpers for the priority scan encoder.
//   state_t      - controller state (IDLE: nothing pending, EMIT: beats pending)
//   MODE_SINGLE  - emit only the priority bit of each vector
//   MODE_SCAN    - emit every set bit, one beat each
//   popcount()   - population count over a zero-extended vector
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int MODE_SINGLE = 0;
  localparam int MODE_SCAN   = 1;

  // Widest vector popcount() accepts; callers zero-extend into this width.
  localparam int POP_MAX_W = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational priority finder.
//   vec   in  WIDTH  vector to search
//   idx   out IDX_W  index of the priority set bit (0 when vec is empty)
//   found out 1      at least one bit of vec is set
//   more  out 1      more than one bit of vec is set
// MSB_FIRST = 0 gives priority to the lowest index, 1 to the highest.
module prio_find #(
  parameter  int WIDTH     = 16,
  parameter  int MSB_FIRST = 0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             more
);

  always_comb begin
    idx = '0;
    // Walk toward the priority end so the last match is the winner.
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  assign found = |vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign more  = |(vec & (vec - WIDTH'(1)));

endmodule

// File: rtl/prio_scan_encoder.sv
// prio_scan_encoder: accepts a request vector and emits encoded bit indices.
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  acceptance enable (does not stall a vector in flight)
//   in_vec/in_valid/in_ready      request vector handshake
//   out_idx/out_last/out_zero/out_count/out_valid/out_ready  beat handshake
// MODE_SINGLE emits one beat per vector; MODE_SCAN emits one beat per set bit.
// An all-zero vector produces a single beat flagged out_zero.
module prio_scan_encoder
  import prio_enc_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MODE      = 0,
  parameter  int MSB_FIRST = 0,
  localparam int IDX_W     = $clog2(WIDTH),
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_zero_q, out_zero_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic                 fire;
  logic                 accept;
  logic                 refresh;
  logic [WIDTH-1:0]     pend_clr;
  logic [POP_MAX_W-1:0] pop_ext;
  logic [IDX_W-1:0]     find_idx;
  logic                 find_found;
  logic                 find_more;

  assign fire     = out_valid_q & out_ready;
  assign in_ready = en & ((state_q == IDLE) | (fire & out_last_q));
  assign accept   = in_valid & in_ready;

  // State, pending vector and count. refresh marks cycles where the beat
  // fields must be recomputed from the new pending vector.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    refresh     = 1'b0;
    pend_clr    = pend_q;
    pend_clr[out_idx_q] = 1'b0;
    pop_ext     = '0;
    pop_ext[WIDTH-1:0] = in_vec;

    if (accept) begin
      // Also covers a last-beat handshake in the same cycle: no bubble.
      state_d     = EMIT;
      pend_d      = in_vec;
      out_count_d = CNT_W'(popcount(pop_ext));
      out_valid_d = 1'b1;
      refresh     = 1'b1;
    end else if (fire) begin
      if (out_last_q) begin
        state_d     = IDLE;
        pend_d      = '0;
        out_valid_d = 1'b0;
      end else begin
        pend_d  = pend_clr;
        refresh = 1'b1;
      end
    end
  end

  // Beat fields are derived from the next pending vector so they can be
  // registered and presented one cycle after the vector changes.
  prio_find #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_find (
    .vec   (pend_d),
    .idx   (find_idx),
    .found (find_found),
    .more  (find_more)
  );

  always_comb begin
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    out_zero_d = out_zero_q;
    if (refresh) begin
      out_idx_d  = find_found ? find_idx : '0;
      out_zero_d = ~find_found;
      out_last_d = (MODE == MODE_SINGLE) ? 1'b1 : ~find_more;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_zero  = out_zero_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Directed bench for prio_scan_encoder (WIDTH = 16) with three instances:
//   u0: MODE single, LSB priority; u1: MODE scan, LSB priority;
//   u2: MODE scan, MSB priority. All share the input side.
module tb_prio_scan_encoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] in_vec;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready_0, in_ready_1, in_ready_2;
  logic [3:0] out_idx_0, out_idx_1, out_idx_2;
  logic       out_last_0, out_last_1, out_last_2;
  logic       out_zero_0, out_zero_1, out_zero_2;
  logic [4:0] out_count_0, out_count_1, out_count_2;
  logic       out_valid_0, out_valid_1, out_valid_2;

  int n_checks;
  int n_fail;

  prio_scan_encoder #(.WIDTH(16), .MODE(0), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_0), .out_idx(out_idx_0), .out_last(out_last_0),
    .out_zero(out_zero_0), .out_count(out_count_0), .out_valid(out_valid_0),
    .out_ready(out_ready)
  );

  prio_scan_encoder #(.WIDTH(16), .MODE(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_1), .out_idx(out_idx_1), .out_last(out_last_1),
    .out_zero(out_zero_1), .out_count(out_count_1), .out_valid(out_valid_1),
    .out_ready(out_ready)
  );

  prio_scan_encoder #(.WIDTH(16), .MODE(1), .MSB_FIRST(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_2), .out_idx(out_idx_2), .out_last(out_last_2),
    .out_zero(out_zero_2), .out_count(out_count_2), .out_valid(out_valid_2),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag,
                            input logic v, input logic [3:0] i, input logic l,
                            input logic z, input logic [4:0] c,
                            input logic ev, input logic [3:0] ei, input logic el,
                            input logic ez, input logic [4:0] ec);
    n_checks++;
    assert (v === ev) else begin
      n_fail++;
      $error("FAIL %s.valid observed=%b expected=%b", tag, v, ev);
    end
    n_checks++;
    assert (i === ei) else begin
      n_fail++;
      $error("FAIL %s.idx observed=%0d expected=%0d", tag, i, ei);
    end
    n_checks++;
    assert (l === el) else begin
      n_fail++;
      $error("FAIL %s.last observed=%b expected=%b", tag, l, el);
    end
    n_checks++;
    assert (z === ez) else begin
      n_fail++;
      $error("FAIL %s.zero observed=%b expected=%b", tag, z, ez);
    end
    n_checks++;
    assert (c === ec) else begin
      n_fail++;
      $error("FAIL %s.count observed=%0d expected=%0d", tag, c, ec);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

    // Reset state and in_ready tracking en after release.
    cyc();
    check_beat("rst_u1", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b0, 4'd0, 1'b0, 1'b0, 5'd0);
    en = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk1("rst_ready_en0", in_ready_1, 1'b0);
    en = 1'b1;
    #1;
    chk1("rst_ready_en1", in_ready_0, 1'b1);
    cyc();

    // Single mode, one-hot vector.
    do_reset();
    in_vec   = 16'h0400;
    in_valid = 1'b1;
    #1;
    chk1("s0400_ready", in_ready_0, 1'b1);
    chk1("s0400_nolat", out_valid_0, 1'b0);
    cyc();
    in_valid = 1'b0;
    check_beat("s0400_b0", out_valid_0, out_idx_0, out_last_0, out_zero_0, out_count_0,
               1'b1, 4'd10, 1'b1, 1'b0, 5'd1);
    cyc();
    chk1("s0400_done", out_valid_0, 1'b0);

    // Scan mode, both priority directions; in_vec changes after acceptance.
    do_reset();
    in_vec   = 16'h8012;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_vec   = 16'hFFFF;
    check_beat("lsb8012_b0", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd1, 1'b0, 1'b0, 5'd3);
    check_beat("msb8012_b0", out_valid_2, out_idx_2, out_last_2, out_zero_2, out_count_2,
               1'b1, 4'd15, 1'b0, 1'b0, 5'd3);
    cyc();
    check_beat("lsb8012_b1", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd4, 1'b0, 1'b0, 5'd3);
    check_beat("msb8012_b1", out_valid_2, out_idx_2, out_last_2, out_zero_2, out_count_2,
               1'b1, 4'd4, 1'b0, 1'b0, 5'd3);
    cyc();
    check_beat("lsb8012_b2", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd15, 1'b1, 1'b0, 5'd3);
    check_beat("msb8012_b2", out_valid_2, out_idx_2, out_last_2, out_zero_2, out_count_2,
               1'b1, 4'd1, 1'b1, 1'b0, 5'd3);
    cyc();
    chk1("lsb8012_done", out_valid_1, 1'b0);
    chk1("msb8012_done", out_valid_2, 1'b0);

    // All-zero vector.
    do_reset();
    in_vec   = 16'h0000;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_beat("zero_b0", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd0, 1'b1, 1'b1, 5'd0);
    cyc();
    chk1("zero_done", out_valid_1, 1'b0);
    chk1("zero_idle", in_ready_1, 1'b1);

    // Backpressure: hold idx 5 for three cycles.
    do_reset();
    in_vec   = 16'h00F0;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_beat("bp_b0", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd4, 1'b0, 1'b0, 5'd4);
    cyc();
    out_ready = 1'b0;
    check_beat("bp_b1", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd5, 1'b0, 1'b0, 5'd4);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_beat($sformatf("bp_hold%0d", k), out_valid_1, out_idx_1, out_last_1,
                 out_zero_1, out_count_1, 1'b1, 4'd5, 1'b0, 1'b0, 5'd4);
    end
    out_ready = 1'b1;
    cyc();
    check_beat("bp_b2", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd6, 1'b0, 1'b0, 5'd4);
    cyc();
    check_beat("bp_b3", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd7, 1'b1, 1'b0, 5'd4);
    cyc();
    chk1("bp_done", out_valid_1, 1'b0);

    // Back-to-back with no bubble.
    do_reset();
    in_vec   = 16'h0003;
    in_valid = 1'b1;
    cyc();
    in_vec = 16'h0100;
    check_beat("b2b_b0", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd0, 1'b0, 1'b0, 5'd2);
    chk1("b2b_busy", in_ready_1, 1'b0);
    cyc();
    check_beat("b2b_b1", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd1, 1'b1, 1'b0, 5'd2);
    chk1("b2b_ready_last", in_ready_1, 1'b1);
    cyc();
    in_valid = 1'b0;
    check_beat("b2b_b2", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd8, 1'b1, 1'b0, 5'd1);
    cyc();
    chk1("b2b_done", out_valid_1, 1'b0);

    // en low blocks the second vector but not the drain of the first.
    do_reset();
    in_vec   = 16'h0003;
    in_valid = 1'b1;
    cyc();
    en     = 1'b0;
    in_vec = 16'h0100;
    check_beat("en_b0", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd0, 1'b0, 1'b0, 5'd2);
    cyc();
    check_beat("en_b1", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd1, 1'b1, 1'b0, 5'd2);
    chk1("en_blocked", in_ready_1, 1'b0);
    cyc();
    chk1("en_nobeat", out_valid_1, 1'b0);
    en = 1'b1;
    #1;
    chk1("en_ready", in_ready_1, 1'b1);
    cyc();
    in_valid = 1'b0;
    check_beat("en_b2", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd8, 1'b1, 1'b0, 5'd1);
    cyc();

    // Reset in the middle of a scan.
    do_reset();
    in_vec   = 16'hFFFF;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_beat("rs_b0", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd0, 1'b0, 1'b0, 5'd16);
    cyc();
    cyc();
    check_beat("rs_b2", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b1, 4'd2, 1'b0, 1'b0, 5'd16);
    rst_n = 1'b0;
    #1;
    check_beat("rs_async", out_valid_1, out_idx_1, out_last_1, out_zero_1, out_count_1,
               1'b0, 4'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk1("rs_ready", in_ready_1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk1($sformatf("rs_nostale%0d", k), out_valid_1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
